// File: rtl/bitwise16_unit_if.sv
// Bus bundle for bitwise16_unit: operands, op select, capture strobe and all results.
// BITWISE16_XOR_EN adds the xor_out signal to the bundle.
interface bitwise16_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             in_valid;
  logic [WIDTH-1:0] not_out;
  logic [WIDTH-1:0] and_out;
  logic [WIDTH-1:0] or_out;
`ifdef BITWISE16_XOR_EN
  logic [WIDTH-1:0] xor_out;
`endif
  logic [WIDTH-1:0] result;
  logic             out_valid;

  modport master (
    output a, b, op, in_valid,
`ifdef BITWISE16_XOR_EN
    input  xor_out,
`endif
    input  not_out, and_out, or_out, result, out_valid
  );

  modport slave (
    input  a, b, op, in_valid,
`ifdef BITWISE16_XOR_EN
    output xor_out,
`endif
    output not_out, and_out, or_out, result, out_valid
  );
endinterface

// File: rtl/bitwise16_unit.sv
// Hack 16-bit bitwise unit: NOT/AND/OR gates plus an op-selected registered result.
// Optional feature macro BITWISE16_XOR_EN: op=11 selects a^b and xor_out is driven; otherwise op=11 passes a.
module bitwise16_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = 16'h0000
) (
  input logic            clk,
  input logic            rst,
  bitwise16_unit_if.slave bus
);

  logic [WIDTH-1:0] not_s;
  logic [WIDTH-1:0] and_s;
  logic [WIDTH-1:0] or_s;
  logic [WIDTH-1:0] xor_s;
  logic [WIDTH-1:0] f_s;
  logic [WIDTH-1:0] result_r;
  logic             out_valid_r;

  // Per-bit gates: bit i sees only a[i]/b[i], so an X stays confined to its own lane.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      assign not_s[i] = ~bus.a[i];
      assign and_s[i] = bus.a[i] & bus.b[i];
      assign or_s[i]  = bus.a[i] | bus.b[i];
      assign xor_s[i] = bus.a[i] ^ bus.b[i];
    end
  endgenerate

  assign bus.not_out = not_s;
  assign bus.and_out = and_s;
  assign bus.or_out  = or_s;
`ifdef BITWISE16_XOR_EN
  assign bus.xor_out = xor_s;
`endif

  // Op select for the registered path, reusing the same gate outputs as the combinational ports.
  always_comb begin
    f_s = bus.a;
    case (bus.op)
      2'b00:   f_s = not_s;
      2'b01:   f_s = and_s;
      2'b10:   f_s = or_s;
`ifdef BITWISE16_XOR_EN
      2'b11:   f_s = xor_s;
`else
      2'b11:   f_s = bus.a;
`endif
      default: f_s = bus.a;
    endcase
  end

`ifndef BITWISE16_XOR_EN
  // xor_s has no consumer in this build; fold it in harmlessly so every gate lane is referenced.
  logic unused_xor_s;
  assign unused_xor_s = ^xor_s;
`endif

  // Result register: reset wins over a same-cycle capture request; idle cycles hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r    <= RESET_VAL;
      out_valid_r <= 1'b0;
    end else if (bus.in_valid) begin
      result_r    <= f_s;
      out_valid_r <= 1'b1;
    end else begin
      result_r    <= result_r;
      out_valid_r <= 1'b0;
    end
  end

  assign bus.result    = result_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_bitwise16_unit.sv
// Self-checking bench for bitwise16_unit: combinational gates checked after each drive,
// registered path checked through a per-cycle scoreboard queue.
module tb_bitwise16_unit;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   miss_cnt;

  logic [16:0] sb_q[$];
  logic [15:0] model_result;

  bitwise16_unit_if #(.WIDTH(16)) bus ();

  bitwise16_unit #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      case (op)
        2'b00:   r[k] = (a[k] == 1'b0);
        2'b01:   r[k] = a[k] && b[k];
        2'b10:   r[k] = a[k] || b[k];
`ifdef BITWISE16_XOR_EN
        default: r[k] = (a[k] != b[k]);
`else
        default: r[k] = a[k];
`endif
      endcase
    end
    return r;
  endfunction

  // One cycle: drive at negedge, check gates, push expectation, check registered outputs after posedge.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                      input logic iv, input logic rs,
                      input logic [15:0] en, input logic [15:0] ea, input logic [15:0] eo,
                      input logic chk_gates);
    logic [16:0] exp;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.op = op; bus.in_valid = iv; rst = rs;
    #1;
    if (chk_gates) begin
      check_eq("not_out", bus.not_out, en);
      check_eq("and_out", bus.and_out, ea);
      check_eq("or_out",  bus.or_out,  eo);
`ifdef BITWISE16_XOR_EN
      check_eq("xor_out", bus.xor_out, ref_f(2'b11, a, b));
`endif
    end
    if (rs) begin
      model_result = 16'h0000;
      sb_q.push_back({1'b0, model_result});
    end else if (iv) begin
      model_result = ref_f(op, a, b);
      sb_q.push_back({1'b1, model_result});
    end else begin
      sb_q.push_back({1'b0, model_result});
    end
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check_eq("out_valid", {15'h0000, bus.out_valid}, {15'h0000, exp[16]});
    check_eq("result",    bus.result, exp[15:0]);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [1:0]  rop;
    logic        riv;
    logic        rrs;
    vec_cnt = 0;
    miss_cnt = 0;
    model_result = 16'h0000;
    rst = 1'b1;
    bus.a = 16'h0000; bus.b = 16'h0000; bus.op = 2'b00; bus.in_valid = 1'b0;

    // Reset state
    step(16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
    // Reference vectors with fixed expectations
    step(16'h0000, 16'hFFFF, 2'b10, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1);
    step(16'hAAAA, 16'h5555, 2'b00, 1'b1, 1'b0, 16'h5555, 16'h0000, 16'hFFFF, 1'b1);
    step(16'hF0F0, 16'h0FF0, 2'b01, 1'b1, 1'b0, 16'h0F0F, 16'h00F0, 16'hFFF0, 1'b1);
    step(16'h1234, 16'h5678, 2'b01, 1'b1, 1'b0, 16'hEDCB, 16'h1230, 16'h567C, 1'b1);
    check_eq("result_1230", bus.result, 16'h1230);
    // Idle: result holds 1230, out_valid drops
    step(16'hFFFF, 16'hFFFF, 2'b10, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1);
    check_eq("hold_1230", bus.result, 16'h1230);
    // Reset with a capture request: request dropped
    step(16'hFFFF, 16'hFFFF, 2'b10, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1);
    check_eq("rst_drop", bus.result, 16'h0000);
    // op=11 boundary
    step(16'hFFFF, 16'hFFFF, 2'b11, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1);
`ifdef BITWISE16_XOR_EN
    check_eq("op11_xor", bus.result, 16'h0000);
`else
    check_eq("op11_pass", bus.result, 16'hFFFF);
`endif
    // Back-to-back captures, every op
    step(16'h1234, 16'h5678, 2'b00, 1'b1, 1'b0, 16'hEDCB, 16'h1230, 16'h567C, 1'b1);
    step(16'h1234, 16'h5678, 2'b10, 1'b1, 1'b0, 16'hEDCB, 16'h1230, 16'h567C, 1'b1);
    step(16'h1234, 16'h5678, 2'b11, 1'b1, 1'b0, 16'hEDCB, 16'h1230, 16'h567C, 1'b1);

    // Random traffic, occasional reset
    for (int n = 0; n < 200; n++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 2'($urandom_range(0, 3));
      riv = ($urandom_range(0, 3) != 0);
      rrs = ($urandom_range(0, 19) == 0);
      step(ra, rb, rop, riv, rrs, ~ra, ra & rb, ra | rb, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
